// File: rtl/wb_pkg.sv
// Shared encodings for the SWIS-V write-back stage.
// Result-source selects and load funct3 values.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_CSR = 2'b11
    } res_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

endpackage

// File: rtl/load_align.sv
// Load byte/halfword lane extraction with sign/zero extension.
// Lanes are taken from the low 32 bits of the memory word.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_data,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data
);

    logic [31:0] word;
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign word   = mem_data[31:0];
    assign byte_l = word[{addr_lo, 3'b000} +: 8];
    assign half_l = addr_lo[1] ? word[31:16] : word[15:0];

    // Pick the lane and extend it to the datapath width.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = XLEN'(signed'(byte_l));
            F3_LH:   load_data = XLEN'(signed'(half_l));
            F3_LW:   load_data = XLEN'(signed'(word));
            F3_LBU:  load_data = XLEN'(byte_l);
            F3_LHU:  load_data = XLEN'(half_l);
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered, handshaked write-back stage with bypass outputs.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic              i_RegWrite,
    input  logic [REG_AW-1:0] i_Rd,
    input  logic [1:0]        i_ResultSrc,
    input  logic [2:0]        i_Funct3,
    input  logic [1:0]        i_Addr_Lo,
    input  logic [XLEN-1:0]   i_Result,
    input  logic [XLEN-1:0]   i_Mem_Data,
    input  logic [XLEN-1:0]   i_Pc_4,
    input  logic [XLEN-1:0]   i_Csr_Data,
    input  logic              i_rf_ready,
    output logic              o_RegWrite,
    output logic [REG_AW-1:0] o_Rd,
    output logic [XLEN-1:0]   o_Wb_Data,
    output logic              o_fwd_valid,
    output logic [REG_AW-1:0] o_fwd_Rd,
    output logic [XLEN-1:0]   o_fwd_Data
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       o_instret
`endif
);

    logic              full;
    logic              wr_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   data_q;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   res_mux;
    logic              accept;
    logic              retire;

    assign o_ready = !full || i_rf_ready;
    assign accept  = i_valid && o_ready && !i_flush;
    assign retire  = full && i_rf_ready;

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .mem_data  (i_Mem_Data),
        .addr_lo   (i_Addr_Lo),
        .funct3    (i_Funct3),
        .load_data (ld_data)
    );

    // Select the write-back value on the input side.
    always_comb begin
        res_mux = i_Result;
        case (res_src_e'(i_ResultSrc))
            RES_ALU: res_mux = i_Result;
            RES_MEM: res_mux = ld_data;
            RES_PC4: res_mux = i_Pc_4;
            RES_CSR: res_mux = i_Csr_Data;
            default: res_mux = i_Result;
        endcase
    end

    // Occupancy: flush wins, then accept, then retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (i_flush) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
        end else if (retire) begin
            full <= 1'b0;
        end
    end

    // Capture the entry once; a held entry is never recomputed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (accept) begin
            wr_q   <= i_RegWrite;
            rd_q   <= i_Rd;
            data_q <= res_mux;
        end
    end

    assign o_RegWrite  = full && wr_q && (rd_q != '0);
    assign o_Rd        = rd_q;
    assign o_Wb_Data   = data_q;
    assign o_fwd_valid = o_RegWrite;
    assign o_fwd_Rd    = rd_q;
    assign o_fwd_Data  = data_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Count every retire edge, including one coinciding with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases then random traffic.
// Writes are checked by a negedge monitor against a queue of expected writes.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_flush = 1'b0;
    logic        i_RegWrite = 1'b0;
    logic [4:0]  i_Rd = '0;
    logic [1:0]  i_ResultSrc = '0;
    logic [2:0]  i_Funct3 = '0;
    logic [1:0]  i_Addr_Lo = '0;
    logic [31:0] i_Result = '0;
    logic [31:0] i_Mem_Data = '0;
    logic [31:0] i_Pc_4 = '0;
    logic [31:0] i_Csr_Data = '0;
    logic        i_rf_ready = 1'b0;
    logic        o_RegWrite;
    logic [4:0]  o_Rd;
    logic [31:0] o_Wb_Data;
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_Rd;
    logic [31:0] o_fwd_Data;
`ifdef WB_INSTRET_EN
    logic [63:0] o_instret;
`endif

    wb_stage #(
        .XLEN(32),
        .REG_AW(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_flush     (i_flush),
        .i_RegWrite  (i_RegWrite),
        .i_Rd        (i_Rd),
        .i_ResultSrc (i_ResultSrc),
        .i_Funct3    (i_Funct3),
        .i_Addr_Lo   (i_Addr_Lo),
        .i_Result    (i_Result),
        .i_Mem_Data  (i_Mem_Data),
        .i_Pc_4      (i_Pc_4),
        .i_Csr_Data  (i_Csr_Data),
        .i_rf_ready  (i_rf_ready),
        .o_RegWrite  (o_RegWrite),
        .o_Rd        (o_Rd),
        .o_Wb_Data   (o_Wb_Data),
        .o_fwd_valid (o_fwd_valid),
        .o_fwd_Rd    (o_fwd_Rd),
        .o_fwd_Data  (o_fwd_Data)
`ifdef WB_INSTRET_EN
        ,
        .o_instret   (o_instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mfull = 0;
    bit          mwr = 0;
    logic [63:0] minstret = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_data(
        input logic [1:0] src, input logic [2:0] f3,
        input logic [1:0] alo, input logic [31:0] res,
        input logic [31:0] mem, input logic [31:0] pc4,
        input logic [31:0] csr);
        int unsigned b;
        int unsigned h;
        if (src == 2'd0) return res;
        if (src == 2'd2) return pc4;
        if (src == 2'd3) return csr;
        b = (mem >> (8 * int'(alo))) & 32'hFF;
        h = (mem >> (16 * (int'(alo) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return mem;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive at posedge+1, return at next posedge+1.
    task automatic cyc(input logic v, input logic wr, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] res,
                       input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [31:0] csr, input logic rfr,
                       input logic fl);
        bit rdy, acc, ret;
        i_valid = v; i_RegWrite = wr; i_Rd = rd; i_ResultSrc = src;
        i_Funct3 = f3; i_Addr_Lo = alo; i_Result = res;
        i_Mem_Data = mem; i_Pc_4 = pc4; i_Csr_Data = csr;
        i_rf_ready = rfr; i_flush = fl;
        rdy = !mfull || rfr;
        #1 chk("o_ready", 64'(o_ready), 64'(rdy));
        @(posedge clk);
        acc = v && rdy && !fl;
        ret = mfull && rfr;
        if (ret) minstret++;
        if (fl && mfull && !ret && mwr && exp_q.size() > 0)
            void'(exp_q.pop_back());
        if (fl) mfull = 0;
        else if (acc) mfull = 1;
        else if (ret) mfull = 0;
        if (acc) begin
            mwr = wr && (rd != 0);
            if (mwr)
                exp_q.push_back('{rd, ref_data(src, f3, alo, res, mem, pc4, csr)});
        end
        #1;
`ifdef WB_INSTRET_EN
        chk("o_instret", o_instret, minstret);
`endif
    endtask

    task automatic idle(input logic rfr);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rfr, 0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res,
                       input logic rfr, input logic fl);
        cyc(1, 1, rd, 2'd0, 3'd0, 2'd0, res, 0, 0, 0, rfr, fl);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_regwrite"}, 64'(o_RegWrite), 0);
        chk({tag, "_fwd_valid"}, 64'(o_fwd_valid), 0);
        chk({tag, "_rd"}, 64'(o_Rd), 0);
        chk({tag, "_wb_data"}, 64'(o_Wb_Data), 0);
        chk({tag, "_fwd_rd"}, 64'(o_fwd_Rd), 0);
        chk({tag, "_fwd_data"}, 64'(o_fwd_Data), 0);
        chk({tag, "_ready"}, 64'(o_ready), 1);
`ifdef WB_INSTRET_EN
        chk({tag, "_instret"}, o_instret, 0);
`endif
    endtask

    // Monitor: a write happens on the edge after a negedge with strobe and grant.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && o_RegWrite && i_rf_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected none",
                         o_Rd, o_Wb_Data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rd", 64'(o_Rd), 64'(e.rd));
                chk("wr_data", 64'(o_Wb_Data), 64'(e.data));
                chk("fwd_valid", 64'(o_fwd_valid), 1);
                chk("fwd_rd", 64'(o_fwd_Rd), 64'(e.rd));
                chk("fwd_data", 64'(o_fwd_Data), 64'(e.data));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_zero_outs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        alu(5'd5, 32'h1234_5678, 1, 0);
        chk("alu_regwrite", 64'(o_RegWrite), 1);
        chk("alu_rd", 64'(o_Rd), 5);
        chk("alu_data", 64'(o_Wb_Data), 64'h1234_5678);
        chk("alu_fwd_valid", 64'(o_fwd_valid), 1);

        cyc(1, 1, 6, 2'd1, 3'd0, 2'd3, 0, 32'h80FF_7F01, 0, 0, 1, 0);
        chk("lb_data", 64'(o_Wb_Data), 64'hFFFF_FF80);
        cyc(1, 1, 7, 2'd1, 3'd4, 2'd3, 0, 32'h80FF_7F01, 0, 0, 1, 0);
        chk("lbu_data", 64'(o_Wb_Data), 64'h0000_0080);
        cyc(1, 1, 8, 2'd1, 3'd1, 2'd2, 0, 32'h80FF_7F01, 0, 0, 1, 0);
        chk("lh_data", 64'(o_Wb_Data), 64'hFFFF_80FF);

        alu(5'd9, 32'hA5A5_0009, 1, 0);
        for (int i = 0; i < 3; i++) begin
            alu(5'd10, 32'h5A5A_0010, 0, 0);
            chk("stall_ready", 64'(o_ready), 0);
            chk("stall_rd", 64'(o_Rd), 9);
            chk("stall_data", 64'(o_Wb_Data), 64'hA5A5_0009);
            chk("stall_regwrite", 64'(o_RegWrite), 1);
        end
        alu(5'd10, 32'h0000_00AA, 1, 0);
        chk("b2b_rd", 64'(o_Rd), 10);
        chk("b2b_data", 64'(o_Wb_Data), 64'h0000_00AA);

        alu(5'd0, 32'h0000_DEAD, 1, 0);
        chk("rd0_regwrite", 64'(o_RegWrite), 0);
        chk("rd0_fwd_valid", 64'(o_fwd_valid), 0);
        idle(1);

        alu(5'd11, 32'h0000_0011, 1, 0);
        alu(5'd12, 32'h0000_0022, 0, 1);
        chk("flush_regwrite", 64'(o_RegWrite), 0);
        chk("flush_ready", 64'(o_ready), 1);
        idle(1);
        chk("flush_nocapture", 64'(o_RegWrite), 0);

        alu(5'd13, 32'h0000_0033, 0, 0);
        idle(0);
        #2 rst_n = 1'b0;
        mfull = 0;
        mwr = 0;
        exp_q.delete();
        minstret = '0;
        #1 chk_zero_outs("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 2000; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, rd,
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0);
        end

        repeat (3) idle(1);
        chk("drain_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
